// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUSel encodings, RV32I opcodes and immediate formats.
// The issue stage and the ALU both import this, so the select encoding is identical at both ends.
package alu_pkg;

  localparam int unsigned SEL_W = 4;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SEL_A = 4'b1110;
  localparam logic [3:0] ALU_SEL_B = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Sign-extended 32-bit immediate for the given instruction format.
  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_type_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (decode input) and downstream (ALU operand/select) handshake bundle of the issue stage.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1_data;
  logic [XLEN-1:0]  in_rs2_data;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data_a;
  logic [XLEN-1:0]  out_data_b;
  logic [SEL_W-1:0] out_alu_sel;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic             out_rd_we;
  logic             out_illegal;

  // Environment side: feeds instructions and consumes issued operands.
  modport master (
    output in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_data_a, out_data_b, out_alu_sel,
           out_pc, out_rd, out_rd_we, out_illegal
  );

  // Issue stage side.
  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_data_a, out_data_b, out_alu_sel,
           out_pc, out_rd, out_rd_we, out_illegal
  );
endinterface

// File: rtl/alu_issue_skid.sv
// Generic 2-entry registered skid buffer: main register M drives the output, S catches one
// extra entry so in_ready depends only on registered state.
module alu_issue_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid, s_valid;
  logic [WIDTH-1:0] m_data, s_data;
  logic             m_xfer, in_xfer;

  always_comb begin
    m_xfer  = m_valid & out_ready;
    in_xfer = in_valid & ~s_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      // Input is blocked while S holds; S only ever refills M.
      if (m_xfer) begin
        m_data  <= s_data;
        s_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!m_valid || m_xfer) begin
        m_data  <= in_data;
        m_valid <= 1'b1;
      end else begin
        s_data  <= in_data;
        s_valid <= 1'b1;
      end
    end else if (m_xfer) begin
      m_valid <= 1'b0;
    end
  end

  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes each accepted instruction into ALU operands and ALUSel,
// then presents them to execute through a registered skid buffer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_issue_stage_if.slave   bus
);

  localparam int unsigned PW = 3 * XLEN + SEL_W + 5 + 1 + 1;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  logic [XLEN-1:0]  dec_a, dec_b;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_writes, dec_illegal, dec_rd_we;
  logic [PW-1:0]    in_payload, out_payload;

  function automatic logic [XLEN-1:0] imm_x(input logic [31:0] inst, input imm_type_e fmt);
    return XLEN'($signed(gen_imm(inst, fmt)));
  endfunction

  always_comb begin
    opcode      = bus.in_inst[6:0];
    funct3      = bus.in_inst[14:12];
    rd          = bus.in_inst[11:7];
    dec_a       = '0;
    dec_b       = '0;
    dec_sel     = SEL_W'(ALU_ADD);
    dec_writes  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a      = bus.in_rs1_data;
        dec_b      = bus.in_rs2_data;
        dec_sel    = SEL_W'({bus.in_inst[30], funct3});
        dec_writes = 1'b1;
      end
      OPC_OP_IMM: begin
        // inst[30] only distinguishes SRAI from SRLI; for other funct3 it is immediate data.
        dec_a      = bus.in_rs1_data;
        dec_b      = imm_x(bus.in_inst, IMM_I);
        dec_sel    = (funct3 == 3'b101) ? SEL_W'({bus.in_inst[30], funct3})
                                        : SEL_W'({1'b0, funct3});
        dec_writes = 1'b1;
      end
      OPC_LUI: begin
        dec_b      = imm_x(bus.in_inst, IMM_U);
        dec_sel    = SEL_W'(ALU_SEL_B);
        dec_writes = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a      = bus.in_pc;
        dec_b      = imm_x(bus.in_inst, IMM_U);
        dec_writes = 1'b1;
      end
      OPC_JAL: begin
        dec_a      = bus.in_pc;
        dec_b      = imm_x(bus.in_inst, IMM_J);
        dec_writes = 1'b1;
      end
      OPC_JALR: begin
        dec_a      = bus.in_rs1_data;
        dec_b      = imm_x(bus.in_inst, IMM_I);
        dec_writes = 1'b1;
      end
      OPC_BRANCH: begin
        dec_a = bus.in_pc;
        dec_b = imm_x(bus.in_inst, IMM_B);
      end
      OPC_LOAD: begin
        dec_a      = bus.in_rs1_data;
        dec_b      = imm_x(bus.in_inst, IMM_I);
        dec_writes = 1'b1;
      end
      OPC_STORE: begin
        dec_a = bus.in_rs1_data;
        dec_b = imm_x(bus.in_inst, IMM_S);
      end
      default: dec_illegal = 1'b1;
    endcase
    dec_rd_we = dec_writes & (rd != 5'd0);
  end

  assign in_payload = {dec_a, dec_b, dec_sel, bus.in_pc, rd, dec_rd_we, dec_illegal};

  alu_issue_skid #(
    .WIDTH(PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign {bus.out_data_a, bus.out_data_b, bus.out_alu_sel, bus.out_pc,
          bus.out_rd, bus.out_rd_we, bus.out_illegal} = out_payload;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, back-pressure, flush and reset behaviour.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int unsigned checks;
  int unsigned passes;

  alu_issue_stage_if #(.XLEN(32), .SEL_W(4)) bus ();

  alu_issue_stage #(.XLEN(32), .SEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid    = v;
    bus.in_inst     = inst;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
  endtask

  // addi x3,x1,5
  localparam logic [31:0] ADDI = 32'h0050_8193;

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);

    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sel", 32'(bus.out_alu_sel), 32'h0);
    chk("rst_data_a", bus.out_data_a, 32'h0);
    chk("rst_data_b", bus.out_data_b, 32'h0);
    chk("rst_rd_we", 32'(bus.out_rd_we), 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    rst_n = 1'b1;

    // sub x0,x1,x2
    drive(1'b1, 32'h4020_8033, 32'h0, 32'd5, 32'd3);
    tick();
    chk("sub_valid", 32'(bus.out_valid), 32'd1);
    chk("sub_sel", 32'(bus.out_alu_sel), 32'b1000);
    chk("sub_a", bus.out_data_a, 32'd5);
    chk("sub_b", bus.out_data_b, 32'd3);
    chk("sub_rd_we", 32'(bus.out_rd_we), 32'd0);

    // srai x1,x1,3
    drive(1'b1, 32'h4030_D093, 32'h4, 32'h8000_0000, 32'h0);
    tick();
    chk("srai_sel", 32'(bus.out_alu_sel), 32'b1101);
    chk("srai_a", bus.out_data_a, 32'h8000_0000);
    chk("srai_b", bus.out_data_b, 32'h0000_0403);
    chk("srai_rd", 32'(bus.out_rd), 32'd1);
    chk("srai_rd_we", 32'(bus.out_rd_we), 32'd1);
    chk("srai_pc", bus.out_pc, 32'h4);

    // lui x0,0x12345
    drive(1'b1, 32'h1234_5037, 32'h8, 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("lui_sel", 32'(bus.out_alu_sel), 32'b1111);
    chk("lui_a", bus.out_data_a, 32'h0);
    chk("lui_b", bus.out_data_b, 32'h1234_5000);

    // auipc x1,1
    drive(1'b1, 32'h0000_1097, 32'h100, 32'h0, 32'h0);
    tick();
    chk("auipc_sel", 32'(bus.out_alu_sel), 32'b0000);
    chk("auipc_a", bus.out_data_a, 32'h100);
    chk("auipc_b", bus.out_data_b, 32'h1000);
    chk("auipc_rd_we", 32'(bus.out_rd_we), 32'd1);

    drive(1'b1, 32'h0000_007F, 32'h10, 32'h1111_1111, 32'h2222_2222);
    tick();
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("ill_a", bus.out_data_a, 32'h0);
    chk("ill_b", bus.out_data_b, 32'h0);
    chk("ill_sel", 32'(bus.out_alu_sel), 32'h0);
    chk("ill_rd_we", 32'(bus.out_rd_we), 32'd0);

    drive(1'b0, '0, '0, '0, '0);
    tick();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);

    // Back-pressure: offer four entries while stalled, only two fit.
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI, 32'h20, 32'h11, 32'h0);
    tick();
    chk("bp1_valid", 32'(bus.out_valid), 32'd1);
    chk("bp1_a", bus.out_data_a, 32'h11);
    chk("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, ADDI, 32'h24, 32'h22, 32'h0);
    tick();
    chk("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2_a_held", bus.out_data_a, 32'h11);
    drive(1'b1, ADDI, 32'h28, 32'h33, 32'h0);
    tick();
    chk("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3_a_held", bus.out_data_a, 32'h11);
    chk("bp3_pc_held", bus.out_pc, 32'h20);
    drive(1'b1, ADDI, 32'h2C, 32'h44, 32'h0);
    tick();
    chk("bp4_b_held", bus.out_data_b, 32'd5);
    chk("bp4_rd_held", 32'(bus.out_rd), 32'd3);
    drive(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    tick();
    chk("drain1_valid", 32'(bus.out_valid), 32'd1);
    chk("drain1_a", bus.out_data_a, 32'h22);
    chk("drain1_pc", bus.out_pc, 32'h24);
    chk("drain1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("drain2_valid", 32'(bus.out_valid), 32'd0);

    // Flush with M and S full and a new entry offered.
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI, 32'h30, 32'h55, 32'h0);
    tick();
    drive(1'b1, ADDI, 32'h34, 32'h66, 32'h0);
    tick();
    chk("fl_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, ADDI, 32'h38, 32'h77, 32'h0);
    flush = 1'b1;
    tick();
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    tick();
    chk("fl_after1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("fl_after2_valid", 32'(bus.out_valid), 32'd0);

    // Flush while an entry is accepted in the same cycle: it must be discarded.
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI, 32'h40, 32'h88, 32'h0);
    tick();
    chk("fl2_pre_a", bus.out_data_a, 32'h88);
    drive(1'b1, ADDI, 32'h44, 32'h99, 32'h0);
    flush = 1'b1;
    tick();
    chk("fl2_valid", 32'(bus.out_valid), 32'd0);
    chk("fl2_in_ready", 32'(bus.in_ready), 32'd1);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    tick();
    chk("fl2_after_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back store then branch at full throughput.
    drive(1'b1, 32'h0020_A423, 32'h50, 32'h1000, 32'hABCD);
    tick();
    chk("sw_a", bus.out_data_a, 32'h1000);
    chk("sw_b", bus.out_data_b, 32'd8);
    chk("sw_rd_we", 32'(bus.out_rd_we), 32'd0);
    drive(1'b1, 32'hFE00_0EE3, 32'h200, 32'h0, 32'h0);
    tick();
    chk("beq_valid", 32'(bus.out_valid), 32'd1);
    chk("beq_a", bus.out_data_a, 32'h200);
    chk("beq_b", bus.out_data_b, 32'hFFFF_FFFC);
    chk("beq_rd_we", 32'(bus.out_rd_we), 32'd0);

    // Asynchronous reset while both entries are held.
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI, 32'h60, 32'hAA, 32'h0);
    tick();
    drive(1'b1, ADDI, 32'h64, 32'hBB, 32'h0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_sel", 32'(bus.out_alu_sel), 32'h0);
    chk("arst_a", bus.out_data_a, 32'h0);
    drive(1'b0, '0, '0, '0, '0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000_1097, 32'h300, 32'h0, 32'h0);
    #1;
    chk("post_rst_pre_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_a", bus.out_data_a, 32'h300);
    drive(1'b0, '0, '0, '0, '0);
    tick();
    chk("post_rst_drained", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
